// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX pipeline register: ALUOp encodings and width defaults.
package id_ex_stage_pkg;

    typedef enum logic [2:0] {
        ALU_BUBBLE = 3'b000,
        ALU_BRANCH = 3'b001,
        ALU_ANDI   = 3'b010,
        ALU_ADDI   = 3'b100,
        ALU_ORI    = 3'b101,
        ALU_LUI    = 3'b110,
        ALU_RTYPE  = 3'b111
    } alu_op_e;

    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_REG_ADDR_W = 5;
    localparam int IMM_W          = 16;

    localparam logic [DEF_REG_ADDR_W-1:0] ZERO_REG = '0;

endpackage

// File: rtl/id_ex_stage_operand.sv
// Write-back bypass for one operand: substitutes wb_data when the write-back
// stage is writing the register this operand names (register 0 excluded).
module operand_bypass
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_addr,
    input  logic [DATA_WIDTH-1:0] src_data,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic [DATA_WIDTH-1:0] sel_data
);

    logic hit;

    always_comb begin
        hit      = wb_reg_write && (wb_addr != REG_ADDR_W'(ZERO_REG)) && (wb_addr == src_addr);
        sel_data = hit ? wb_data : src_data;
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with stall hold, flush bubble and write-back operand bypass.
module id_ex_stage
    import id_ex_stage_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  flush,
    input  logic                  id_valid,
    input  logic [2:0]            id_alu_op,
    input  logic [5:0]            id_funct,
    input  logic [4:0]            id_shamt,
    input  logic [IMM_W-1:0]      id_imm,
    input  logic [REG_ADDR_W-1:0] id_rs_addr,
    input  logic [REG_ADDR_W-1:0] id_rt_addr,
    input  logic [REG_ADDR_W-1:0] id_rd_addr,
    input  logic [DATA_WIDTH-1:0] id_rs_data,
    input  logic [DATA_WIDTH-1:0] id_rt_data,
    input  logic                  id_reg_dst,
    input  logic                  id_alu_src,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  id_mem_write,
    input  logic                  id_mem_to_reg,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [DATA_WIDTH-1:0] wb_data,
    output logic                  ex_valid,
    output logic [2:0]            ex_alu_op,
    output logic [5:0]            ex_funct,
    output logic [4:0]            ex_shamt,
    output logic [DATA_WIDTH-1:0] ex_rs_data,
    output logic [DATA_WIDTH-1:0] ex_rt_data,
    output logic [DATA_WIDTH-1:0] ex_imm_ext,
    output logic [REG_ADDR_W-1:0] ex_rs_addr,
    output logic [REG_ADDR_W-1:0] ex_rt_addr,
    output logic [REG_ADDR_W-1:0] ex_dest,
    output logic                  ex_alu_src,
    output logic                  ex_reg_write,
    output logic                  ex_mem_read,
    output logic                  ex_mem_write,
    output logic                  ex_mem_to_reg
);

    typedef struct packed {
        logic                  valid;
        logic [2:0]            alu_op;
        logic [5:0]            funct;
        logic [4:0]            shamt;
        logic [DATA_WIDTH-1:0] rs_data;
        logic [DATA_WIDTH-1:0] rt_data;
        logic [DATA_WIDTH-1:0] imm_ext;
        logic [REG_ADDR_W-1:0] rs_addr;
        logic [REG_ADDR_W-1:0] rt_addr;
        logic [REG_ADDR_W-1:0] dest;
        logic                  alu_src;
        logic                  reg_write;
        logic                  mem_read;
        logic                  mem_write;
        logic                  mem_to_reg;
    } ex_regs_t;

    ex_regs_t regs_q, regs_d;

    logic [REG_ADDR_W-1:0] rs_src_addr, rt_src_addr;
    logic [DATA_WIDTH-1:0] rs_src_data, rt_src_data;
    logic [DATA_WIDTH-1:0] rs_sel, rt_sel;

    function automatic logic [DATA_WIDTH-1:0] ext_imm(input logic [2:0] op, input logic [IMM_W-1:0] imm);
        logic [DATA_WIDTH-1:0] r;
        case (op)
            ALU_ORI, ALU_ANDI: r = {{(DATA_WIDTH-IMM_W){1'b0}}, imm};
            ALU_LUI:           r = {imm, {(DATA_WIDTH-IMM_W){1'b0}}};
            default:           r = {{(DATA_WIDTH-IMM_W){imm[IMM_W-1]}}, imm};
        endcase
        return r;
    endfunction

    // While stalled the bypass watches the held operands so they pick up late write-backs.
    always_comb begin
        rs_src_addr = stall ? regs_q.rs_addr : id_rs_addr;
        rt_src_addr = stall ? regs_q.rt_addr : id_rt_addr;
        rs_src_data = stall ? regs_q.rs_data : id_rs_data;
        rt_src_data = stall ? regs_q.rt_data : id_rt_data;
    end

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_rs_bypass (
        .src_addr     (rs_src_addr),
        .src_data     (rs_src_data),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .sel_data     (rs_sel)
    );

    operand_bypass #(.DATA_WIDTH(DATA_WIDTH), .REG_ADDR_W(REG_ADDR_W)) u_rt_bypass (
        .src_addr     (rt_src_addr),
        .src_data     (rt_src_data),
        .wb_reg_write (wb_reg_write),
        .wb_addr      (wb_addr),
        .wb_data      (wb_data),
        .sel_data     (rt_sel)
    );

    // A bubble (flush, or a load of an empty decode slot) clears every field.
    always_comb begin
        regs_d = regs_q;
        if (flush || (!stall && !id_valid)) begin
            regs_d = '0;
        end else if (stall) begin
            regs_d.rs_data = rs_sel;
            regs_d.rt_data = rt_sel;
        end else begin
            regs_d.valid      = 1'b1;
            regs_d.alu_op     = id_alu_op;
            regs_d.funct      = id_funct;
            regs_d.shamt      = id_shamt;
            regs_d.rs_data    = rs_sel;
            regs_d.rt_data    = rt_sel;
            regs_d.imm_ext    = ext_imm(id_alu_op, id_imm);
            regs_d.rs_addr    = id_rs_addr;
            regs_d.rt_addr    = id_rt_addr;
            regs_d.dest       = id_reg_dst ? id_rd_addr : id_rt_addr;
            regs_d.alu_src    = id_alu_src;
            regs_d.reg_write  = id_reg_write;
            regs_d.mem_read   = id_mem_read;
            regs_d.mem_write  = id_mem_write;
            regs_d.mem_to_reg = id_mem_to_reg;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) regs_q <= '0;
        else        regs_q <= regs_d;
    end

    assign ex_valid      = regs_q.valid;
    assign ex_alu_op     = regs_q.alu_op;
    assign ex_funct      = regs_q.funct;
    assign ex_shamt      = regs_q.shamt;
    assign ex_rs_data    = regs_q.rs_data;
    assign ex_rt_data    = regs_q.rt_data;
    assign ex_imm_ext    = regs_q.imm_ext;
    assign ex_rs_addr    = regs_q.rs_addr;
    assign ex_rt_addr    = regs_q.rt_addr;
    assign ex_dest       = regs_q.dest;
    assign ex_alu_src    = regs_q.alu_src;
    assign ex_reg_write  = regs_q.reg_write;
    assign ex_mem_read   = regs_q.mem_read;
    assign ex_mem_write  = regs_q.mem_write;
    assign ex_mem_to_reg = regs_q.mem_to_reg;

endmodule
